ahb_subordinate_mem: RTL and testbench

AHB_SUBORDINATE_MEM -- requirements
Module: ahb_subordinate_mem

---
 rtl/tb_pack.sv | 43 ++++
 rtl/ahb_sub_lfsr.sv | 29 ++
 rtl/ahb_subordinate_mem.sv | 190 +++++++++++++++++++
 tb/tb_ahb_subordinate_mem.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_pack.sv
// Shared AMBA AHB encodings used by the subordinate memory and its bench.
package tb_pack;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } t_htrans;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } t_hburst;

  typedef enum logic [2:0] {
    HSIZE_W8    = 3'd0,
    HSIZE_W16   = 3'd1,
    HSIZE_W32   = 3'd2,
    HSIZE_W64   = 3'd3,
    HSIZE_W128  = 3'd4,
    HSIZE_W256  = 3'd5,
    HSIZE_W512  = 3'd6,
    HSIZE_W1024 = 3'd7
  } t_hsize;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } t_hresp;

  localparam int unsigned LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ahb_sub_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) stepped once per accepted transfer.
module ahb_sub_lfsr
  import tb_pack::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic              i_hclk,
  input  logic              i_hreset_n,
  input  logic              i_adv,
  output logic [LFSR_W-1:0] o_lfsr
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (i_adv) begin
      lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]} ^ (lfsr_q[0] ? LFSR_TAPS : '0);
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) lfsr_q <= SEED;
    else             lfsr_q <= lfsr_d;
  end

  assign o_lfsr = lfsr_q;

endmodule

// File: rtl/ahb_subordinate_mem.sv
// AHB subordinate memory with pseudo-random wait states and two-cycle ERROR.
// Optional RETRY injection on NONSEQ beats when AHB_SUB_RETRY_INJECT_EN is defined.
module ahb_subordinate_mem
  import tb_pack::*;
#(
  parameter int unsigned DATA_WDT  = 32,
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned WAIT_MAX  = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                i_hclk,
  input  logic                i_hreset_n,
  input  logic                i_hsel,
  input  t_htrans             i_htrans,
  input  t_hburst             i_hburst,
  input  t_hsize              i_hsize,
  input  logic [31:0]         i_haddr,
  input  logic                i_hwrite,
  input  logic [DATA_WDT-1:0] i_hwdata,
  output logic [DATA_WDT-1:0] o_hrdata,
  output logic                o_hready,
  output t_hresp              o_hresp
);

  localparam int unsigned BYTES     = DATA_WDT / 8;
  localparam int unsigned OFF_W     = $clog2(BYTES);
  localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
  localparam int unsigned CNT_W     = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH * BYTES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} t_state;

  t_state              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                hready_q, hready_d;
  t_hresp              hresp_q, hresp_d;
  logic [DATA_WDT-1:0] rdata_q, rdata_d;
  logic                dp_valid_q, dp_valid_d;
  logic                dp_write_q, dp_write_d;
  logic [IDX_W-1:0]    dp_idx_q, dp_idx_d;
  logic [OFF_W-1:0]    dp_off_q, dp_off_d;
  t_hsize              dp_size_q, dp_size_d;
  logic [DATA_WDT-1:0] mem_q [MEM_DEPTH];

  logic [LFSR_W-1:0]   lfsr;
  logic                accept_c, illegal_c, retry_c, wr_en_c, fwd_c, unused_c;
  logic [CNT_W-1:0]    wait_ld_c;
  logic [IDX_W-1:0]    acc_idx_c;
  logic [31:0]         nbytes_c, off_c;
  logic [DATA_WDT-1:0] wmerged_c;

  ahb_sub_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_hclk     (i_hclk),
    .i_hreset_n (i_hreset_n),
    .i_adv      (accept_c),
    .o_lfsr     (lfsr)
  );

  assign accept_c  = i_hsel && hready_q &&
                     ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));
  assign illegal_c = (32'(i_hsize) > OFF_W) ||
                     ((i_haddr & ((32'd1 << i_hsize) - 32'd1)) != 32'd0) ||
                     (i_haddr >= MEM_BYTES);
  assign wait_ld_c = CNT_W'(32'(lfsr[7:0]) % (WAIT_MAX + 1));
  assign acc_idx_c = i_haddr[OFF_W +: IDX_W];
  assign unused_c  = ^{i_hburst, lfsr[LFSR_W-1:8]};

`ifdef AHB_SUB_RETRY_INJECT_EN
  assign retry_c = (i_htrans == HTRANS_NONSEQ) && (lfsr[15:14] == 2'b11);
`else
  assign retry_c = 1'b0;
`endif

  // Write commits at the edge closing the final data cycle.
  assign wr_en_c  = hready_q && dp_valid_q && dp_write_q;
  assign fwd_c    = wr_en_c && (dp_idx_q == acc_idx_c);
  assign nbytes_c = 32'd1 << dp_size_q;
  assign off_c    = 32'(dp_off_q);

  // Little-endian lane merge of write data into the stored word.
  always_comb begin
    wmerged_c = mem_q[dp_idx_q];
    for (int unsigned b = 0; b < BYTES; b++) begin
      if ((b >= off_c) && (b < off_c + nbytes_c)) begin
        wmerged_c[8*b +: 8] = i_hwdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hready_d   = hready_q;
    hresp_d    = hresp_q;
    rdata_d    = rdata_q;
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_idx_d   = dp_idx_q;
    dp_off_d   = dp_off_q;
    dp_size_d  = dp_size_q;

    case (state_q)
      S_IDLE, S_ERR2: begin
        state_d  = S_IDLE;
        hready_d = 1'b1;
        hresp_d  = HRESP_OKAY;
        if (accept_c) begin
          if (illegal_c) begin
            state_d  = S_ERR1;
            hready_d = 1'b0;
            hresp_d  = HRESP_ERROR;
          end else if (retry_c) begin
            state_d  = S_ERR1;
            hready_d = 1'b0;
            hresp_d  = HRESP_RETRY;
          end else if (wait_ld_c != '0) begin
            state_d  = S_WAIT;
            cnt_d    = wait_ld_c;
            hready_d = 1'b0;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_IDLE;
          hready_d = 1'b1;
        end
      end
      S_ERR1: begin
        state_d  = S_ERR2;
        hready_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A new data phase only opens at an edge where hready is high.
    if (hready_q) begin
      dp_valid_d = accept_c && !illegal_c && !retry_c;
      if (accept_c) begin
        dp_write_d = i_hwrite;
        dp_idx_d   = acc_idx_c;
        dp_off_d   = i_haddr[OFF_W-1:0];
        dp_size_d  = i_hsize;
      end
    end

    if (accept_c && !illegal_c && !retry_c && !i_hwrite && (wait_ld_c == '0)) begin
      rdata_d = fwd_c ? wmerged_c : mem_q[acc_idx_c];
    end else if ((state_q == S_WAIT) && (cnt_q == CNT_W'(1)) && !dp_write_q) begin
      rdata_d = mem_q[dp_idx_q];
    end
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hready_q   <= 1'b1;
      hresp_q    <= HRESP_OKAY;
      rdata_q    <= '0;
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_idx_q   <= '0;
      dp_off_q   <= '0;
      dp_size_q  <= HSIZE_W8;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hready_q   <= hready_d;
      hresp_q    <= hresp_d;
      rdata_q    <= rdata_d;
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_idx_q   <= dp_idx_d;
      dp_off_q   <= dp_off_d;
      dp_size_q  <= dp_size_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge i_hclk) begin
    if (wr_en_c) mem_q[dp_idx_q] <= wmerged_c;
  end

  assign o_hrdata = rdata_q;
  assign o_hready = hready_q;
  assign o_hresp  = hresp_q;

endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// Bench: directed vector table on a zero-wait instance, random beats against a byte-array model.
module tb_ahb_subordinate_mem;
  import tb_pack::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        use3 = 1'b0;
  t_htrans     htrans = HTRANS_IDLE;
  t_hburst     hburst = HBURST_SINGLE;
  t_hsize      hsize = HSIZE_W32;
  logic [31:0] haddr = '0;
  logic        hwrite = 1'b0;
  logic [31:0] hwdata = '0;

  logic [31:0] hrdata0, hrdata3, hrdata_m;
  logic        hready0, hready3, hready_m;
  t_hresp      hresp0, hresp3, hresp_m;
  logic        hsel0, hsel3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign hsel0    = sel && !use3;
  assign hsel3    = sel && use3;
  assign hready_m = use3 ? hready3 : hready0;
  assign hresp_m  = use3 ? hresp3 : hresp0;
  assign hrdata_m = use3 ? hrdata3 : hrdata0;

  ahb_subordinate_mem #(.DATA_WDT(32), .MEM_DEPTH(256), .WAIT_MAX(0)) u_dut0 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel0), .i_htrans(htrans),
    .i_hburst(hburst), .i_hsize(hsize), .i_haddr(haddr), .i_hwrite(hwrite),
    .i_hwdata(hwdata), .o_hrdata(hrdata0), .o_hready(hready0), .o_hresp(hresp0)
  );

  ahb_subordinate_mem #(.DATA_WDT(32), .MEM_DEPTH(256), .WAIT_MAX(3)) u_dut3 (
    .i_hclk(clk), .i_hreset_n(rst_n), .i_hsel(hsel3), .i_htrans(htrans),
    .i_hburst(hburst), .i_hsize(hsize), .i_haddr(haddr), .i_hwrite(hwrite),
    .i_hwdata(hwdata), .o_hrdata(hrdata3), .o_hready(hready3), .o_hresp(hresp3)
  );

  typedef struct {
    bit          wr;
    t_hsize      sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_err;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          max_wait;
  } beat_t;

  beat_t       bq[$];
  int          r_waits [256];
  int          r_werr  [256];
  int          r_wnok  [256];
  t_hresp      r_fresp [256];
  logic [31:0] r_rdata [256];
  bit          r_done  [256];
  logic [7:0]  mdl [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic beat_t mk(input bit wr, input t_hsize sz, input logic [31:0] a,
                               input logic [31:0] wd, input bit err, input bit chk_rd,
                               input logic [31:0] rd, input int mw);
    beat_t b;
    b.wr = wr; b.sz = sz; b.addr = a; b.wdata = wd;
    b.exp_err = err; b.chk_rd = chk_rd; b.exp_rd = rd; b.max_wait = mw;
    return b;
  endfunction

  function automatic logic [31:0] mdl_word(input int w);
    return {mdl[4*w+3], mdl[4*w+2], mdl[4*w+1], mdl[4*w]};
  endfunction

  task automatic drive_addr(input int i);
    if (i < bq.size()) begin
      sel = 1'b1; htrans = HTRANS_NONSEQ; haddr = bq[i].addr;
      hwrite = bq[i].wr; hsize = bq[i].sz;
    end else begin
      sel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    end
  endtask

  // Pipelined master: each beat's address overlaps the previous beat's data phase.
  task automatic run_beats(input string tag);
    int n, ai, di, cyc;
    n = bq.size(); ai = 0; di = -1; cyc = 0;
    for (int k = 0; k < n; k++) begin
      r_waits[k] = 0; r_werr[k] = 0; r_wnok[k] = 0;
      r_fresp[k] = HRESP_OKAY; r_rdata[k] = '0; r_done[k] = 1'b0;
    end
    @(posedge clk); #1;
    drive_addr(0);
    while ((di >= 0 || ai < n) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (hready_m) begin
        if (di >= 0) begin
          r_fresp[di] = hresp_m; r_rdata[di] = hrdata_m; r_done[di] = 1'b1;
        end
        di = (ai < n) ? ai : -1;
        if (ai < n) ai++;
        @(posedge clk); #1;
        if (di >= 0) hwdata = bq[di].wdata;
        drive_addr(ai);
      end else begin
        if (di >= 0) begin
          r_waits[di]++;
          if (hresp_m == HRESP_ERROR) r_werr[di]++;
          if (hresp_m != HRESP_OKAY) r_wnok[di]++;
        end
        @(posedge clk); #1;
      end
    end
    chk($sformatf("%s timeout", tag), 32'(cyc < 4000), 32'd1);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s[%0d] done", tag, k), 32'(r_done[k]), 32'd1);
      if (bq[k].exp_err) begin
        chk($sformatf("%s[%0d] resp", tag, k), 32'(r_fresp[k]), 32'(HRESP_ERROR));
        chk($sformatf("%s[%0d] err_wait_cycles", tag, k), 32'(r_waits[k]), 32'd1);
        chk($sformatf("%s[%0d] err_wait_resp", tag, k), 32'(r_werr[k]), 32'd1);
      end else begin
        chk($sformatf("%s[%0d] resp", tag, k), 32'(r_fresp[k]), 32'(HRESP_OKAY));
        chk($sformatf("%s[%0d] wait_resp_not_okay", tag, k), 32'(r_wnok[k]), 32'd0);
        checks++;
        if (r_waits[k] > bq[k].max_wait) begin
          errors++;
          $display("FAIL %s[%0d] wait_cycles: got %0d, allowed 0..%0d", tag, k,
                   r_waits[k], bq[k].max_wait);
        end
      end
      if (bq[k].chk_rd)
        chk($sformatf("%s[%0d] rdata", tag, k), r_rdata[k], bq[k].exp_rd);
    end
  endtask

  task automatic reset_mid_wait();
    bit hit;
    logic [31:0] a;
    hit = 1'b0;
    use3 = 1'b1;
    for (int k = 0; k < 16 && !hit; k++) begin
      a = 32'h80 + 32'(4 * k);
      bq.delete();
      bq.push_back(mk(1, HSIZE_W32, a, 32'h5555_5555, 0, 0, '0, 3));
      run_beats("rst_pre");
      @(posedge clk); #1;
      sel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = a; hsize = HSIZE_W32;
      @(posedge clk); #1;
      sel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0; hwdata = 32'hCAFE_F00D;
      @(negedge clk);
      if (!hready3) begin
        hit = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid hready", 32'(hready3), 32'd1);
        chk("rst_mid hresp", 32'(hresp3), 32'(HRESP_OKAY));
        chk("rst_mid hrdata", hrdata3, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bq.delete();
        bq.push_back(mk(0, HSIZE_W32, a, '0, 0, 1, 32'h5555_5555, 3));
        run_beats("rst_post");
      end else begin
        @(posedge clk);
      end
    end
    chk("rst_mid reached_wait_state", 32'(hit), 32'd1);
  endtask

  initial begin
    beat_t dir_tbl[14];
    int sz, nb, w, off;
    logic [31:0] wd, a;
    bit wr;

    // Directed vectors for the zero-wait instance; expectations are hand-derived.
    dir_tbl[0]  = mk(1, HSIZE_W32, 32'h10,  32'hDEAD_BEEF, 0, 0, '0, 0);
    dir_tbl[1]  = mk(0, HSIZE_W32, 32'h10,  '0,            0, 1, 32'hDEAD_BEEF, 0);
    dir_tbl[2]  = mk(1, HSIZE_W32, 32'h10,  32'h1122_3344, 0, 0, '0, 0);
    dir_tbl[3]  = mk(1, HSIZE_W8,  32'h13,  32'hAA00_0000, 0, 0, '0, 0);
    dir_tbl[4]  = mk(0, HSIZE_W32, 32'h10,  '0,            0, 1, 32'hAA22_3344, 0);
    dir_tbl[5]  = mk(1, HSIZE_W32, 32'h00,  32'h0102_0304, 0, 0, '0, 0);
    dir_tbl[6]  = mk(1, HSIZE_W32, 32'h02,  32'hFFFF_FFFF, 1, 0, '0, 0);
    dir_tbl[7]  = mk(0, HSIZE_W32, 32'h00,  '0,            0, 1, 32'h0102_0304, 0);
    dir_tbl[8]  = mk(0, HSIZE_W32, 32'h400, '0,            1, 0, '0, 0);
    dir_tbl[9]  = mk(0, HSIZE_W32, 32'h00,  '0,            0, 1, 32'h0102_0304, 0);
    dir_tbl[10] = mk(1, HSIZE_W16, 32'h12,  32'hBEEF_0000, 0, 0, '0, 0);
    dir_tbl[11] = mk(0, HSIZE_W64, 32'h00,  '0,            1, 0, '0, 0);
    dir_tbl[12] = mk(0, HSIZE_W8,  32'h10,  '0,            0, 1, 32'hBEEF_3344, 0);
    dir_tbl[13] = mk(0, HSIZE_W16, 32'h11,  '0,            1, 0, '0, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset hready0", 32'(hready0), 32'd1);
    chk("reset hresp0", 32'(hresp0), 32'(HRESP_OKAY));
    chk("reset hrdata0", hrdata0, 32'd0);
    chk("reset hready3", 32'(hready3), 32'd1);
    chk("reset hresp3", 32'(hresp3), 32'(HRESP_OKAY));
    chk("reset hrdata3", hrdata3, 32'd0);
    rst_n = 1'b1;

    use3 = 1'b0;
    bq.delete();
    for (int i = 0; i < 14; i++) bq.push_back(dir_tbl[i]);
    run_beats("dir");

    // Deselected and IDLE/BUSY phases must be ignored with zero waits.
    @(posedge clk); #1;
    sel = 1'b0; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h10;
    hsize = HSIZE_W32; hwdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin sel = 1'b1; htrans = HTRANS_IDLE; end
      if (i == 3) htrans = HTRANS_BUSY;
      @(negedge clk);
      chk($sformatf("ignored_phase[%0d] hready", i), 32'(hready0), 32'd1);
      chk($sformatf("ignored_phase[%0d] hresp", i), 32'(hresp0), 32'(HRESP_OKAY));
      @(posedge clk); #1;
    end
    sel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
    bq.delete();
    bq.push_back(mk(0, HSIZE_W32, 32'h10, '0, 0, 1, 32'hBEEF_3344, 0));
    run_beats("ignored_readback");

    // Random beats on the WAIT_MAX=3 instance against a byte-array model.
    use3 = 1'b1;
    hburst = HBURST_INCR;
    bq.delete();
    for (int k = 0; k < 16; k++) begin
      wd = $urandom;
      bq.push_back(mk(1, HSIZE_W32, 32'(4 * k), wd, 0, 0, '0, 3));
      for (int b = 0; b < 4; b++) mdl[4*k+b] = wd[8*b +: 8];
    end
    for (int k = 0; k < 200; k++) begin
      wr = 1'($urandom_range(0, 1));
      wd = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 2))
          0: a = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
          1: a = 32'h400 + 32'(4 * $urandom_range(0, 63));
          default: a = 32'(8 * $urandom_range(0, 7));
        endcase
        bq.push_back(mk(wr, (a >= 32'h400 || a[1:0] != 2'b00) ? HSIZE_W32 : HSIZE_W64,
                        a, wd, 1, 0, '0, 3));
      end else begin
        sz  = $urandom_range(0, 2);
        nb  = 1 << sz;
        w   = $urandom_range(0, 15);
        off = $urandom_range(0, 4 / nb - 1) * nb;
        a   = 32'(4 * w + off);
        if (wr) begin
          for (int b = off; b < off + nb; b++) mdl[4*w+b] = wd[8*b +: 8];
          bq.push_back(mk(1, t_hsize'(3'(sz)), a, wd, 0, 0, '0, 3));
        end else begin
          bq.push_back(mk(0, t_hsize'(3'(sz)), a, wd, 0, 1, mdl_word(w), 3));
        end
      end
    end
    run_beats("rand");
    hburst = HBURST_SINGLE;

    reset_mid_wait();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
